// File: rtl/channel_buffer_ctrl_if.sv
// Channel-buffer controller bus: frame start, upstream write handshake and
// buffer/frame status. The upstream side uses master; the controller uses slave.
interface channel_buffer_ctrl_if #(
    parameter int MCU_W = 16
);
    logic             start;
    logic [MCU_W-1:0] num_mcus;
    logic             in_valid;
    logic [1:0]       in_ch;
    logic             in_ready;
    logic             buf_wr_en;
    logic [1:0]       buf_ch;
    logic             drain_active;
    logic             mcu_done;
    logic             frame_done;
    logic             busy;
    logic             seq_err;
    logic [MCU_W-1:0] mcus_left;

    modport master (
        output start, num_mcus, in_valid, in_ch,
        input  in_ready, buf_wr_en, buf_ch, drain_active, mcu_done,
               frame_done, busy, seq_err, mcus_left
    );

    modport slave (
        input  start, num_mcus, in_valid, in_ch,
        output in_ready, buf_wr_en, buf_ch, drain_active, mcu_done,
               frame_done, busy, seq_err, mcus_left
    );
endinterface

// File: rtl/channel_buffer_ctrl.sv
// Sequences 4:2:0 channel writes (4 Y, 1 Cb, 1 Cr) into the channel buffer,
// then holds off writes while the buffer drains its 4 output beats per MCU.
module channel_buffer_ctrl #(
    parameter int MCU_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    channel_buffer_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_Y,
        S_CB,
        S_CR,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_ycnt;
    logic [1:0]       r_dcnt;
    logic [MCU_W-1:0] r_mcus_left;
    logic             r_seq_err;
    logic             r_zero_done;

    logic             w_in_ready;
    logic [1:0]       w_exp_ch;
    logic             w_handshake;
    logic             w_write;
    logic             w_bad;
    logic             w_start;
    logic             w_start_nz;
    logic             w_start_zero;
    logic             w_drain_last;
    logic             w_last_mcu;

    always_comb begin
        w_exp_ch   = 2'd0;
        w_in_ready = 1'b0;
        case (r_state)
            S_Y:     w_in_ready = 1'b1;
            S_CB:    begin w_exp_ch = 2'd1; w_in_ready = 1'b1; end
            S_CR:    begin w_exp_ch = 2'd2; w_in_ready = 1'b1; end
            default: begin w_exp_ch = 2'd0; w_in_ready = 1'b0; end
        endcase
    end

    // An out-of-order tag is still consumed; it only raises seq_err.
    assign w_handshake  = bus.in_valid & w_in_ready;
    assign w_write      = w_handshake & (bus.in_ch == w_exp_ch);
    assign w_bad        = w_handshake & (bus.in_ch != w_exp_ch);
    assign w_start      = (r_state == S_IDLE) & bus.start;
    assign w_start_nz   = w_start & (bus.num_mcus != '0);
    assign w_start_zero = w_start & (bus.num_mcus == '0);
    assign w_drain_last = (r_state == S_DRAIN) & (r_dcnt == 2'd3);
    assign w_last_mcu   = (r_mcus_left == MCU_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_nz) w_next_state = S_Y;
            S_Y:     if (w_write && r_ycnt == 2'd3) w_next_state = S_CB;
            S_CB:    if (w_write) w_next_state = S_CR;
            S_CR:    if (w_write) w_next_state = S_DRAIN;
            S_DRAIN: if (r_dcnt == 2'd3) w_next_state = w_last_mcu ? S_IDLE : S_Y;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ycnt wraps to 0 on the 4th Y write, so every MCU starts its Y phase at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ycnt      <= 2'd0;
            r_dcnt      <= 2'd0;
            r_mcus_left <= '0;
            r_seq_err   <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_start_zero;

            if (w_start) begin
                r_seq_err <= 1'b0;
            end else if (w_bad) begin
                r_seq_err <= 1'b1;
            end

            if (w_start_nz) begin
                r_mcus_left <= bus.num_mcus;
                r_ycnt      <= 2'd0;
            end else if (w_drain_last) begin
                r_mcus_left <= r_mcus_left - MCU_W'(1);
                r_ycnt      <= 2'd0;
            end else if (r_state == S_Y && w_write) begin
                r_ycnt <= r_ycnt + 2'd1;
            end

            if (r_state == S_CR && w_write) begin
                r_dcnt <= 2'd0;
            end else if (r_state == S_DRAIN) begin
                r_dcnt <= r_dcnt + 2'd1;
            end
        end
    end

    always_comb begin
        bus.in_ready     = w_in_ready;
        bus.buf_wr_en    = w_write;
        bus.buf_ch       = w_exp_ch;
        bus.drain_active = (r_state == S_DRAIN);
        bus.mcu_done     = w_drain_last;
        bus.frame_done   = (w_drain_last & w_last_mcu) | r_zero_done;
        bus.busy         = (r_state != S_IDLE);
        bus.seq_err      = r_seq_err;
        bus.mcus_left    = r_mcus_left;
    end

endmodule

// File: tb/tb_channel_buffer_ctrl.sv
// Randomized scoreboard bench for channel_buffer_ctrl: a frame-level model
// queues the expected writes and MCU completions, a monitor checks them.
module tb_channel_buffer_ctrl;

    localparam int MCU_W   = 16;
    localparam int K_WRITE = 0;
    localparam int K_MCU   = 1;
    localparam int K_ZERO  = 2;

    typedef struct {
        int               kind;
        logic [1:0]       ch;
        logic [MCU_W-1:0] left;
        logic             fd;
    } event_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    event_t           expQ[$];
    int               modelPos  = 0;
    logic [MCU_W-1:0] modelLeft = '0;
    logic             modelErr  = 1'b0;

    int   drainRun      = 0;
    logic prevFrameDone = 1'b0;

    channel_buffer_ctrl_if #(.MCU_W(MCU_W)) bus ();

    channel_buffer_ctrl #(.MCU_W(MCU_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Channel the frame rules call for next: 4 Y, then Cb, then Cr.
    function automatic logic [1:0] expChan();
        if (modelPos < 4) return 2'd0;
        if (modelPos == 4) return 2'd1;
        return 2'd2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ch);
        event_t ev;
        int     budget;
        budget = 0;
        if (ch == expChan()) begin
            ev = '{kind: K_WRITE, ch: ch, left: '0, fd: 1'b0};
            expQ.push_back(ev);
            modelPos++;
            if (modelPos == 6) begin
                ev = '{kind: K_MCU, ch: 2'd0, left: modelLeft, fd: (modelLeft == MCU_W'(1))};
                expQ.push_back(ev);
                modelLeft = modelLeft - MCU_W'(1);
                modelPos  = 0;
            end
        end else begin
            modelErr = 1'b1;
        end
        bus.in_valid = 1'b1;
        bus.in_ch    = ch;
        while (!bus.in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!bus.in_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL handshake_timeout: in_ready=%0b, expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic startFrame(input logic [MCU_W-1:0] n);
        event_t ev;
        bus.start    = 1'b1;
        bus.num_mcus = n;
        modelLeft    = n;
        modelPos     = 0;
        modelErr     = 1'b0;
        if (n == '0) begin
            ev = '{kind: K_ZERO, ch: 2'd0, left: '0, fd: 1'b1};
            expQ.push_back(ev);
        end
        tick();
        bus.start = 1'b0;
        if (n == '0) begin
            checkOutput("zero_frame_done", 32'(bus.frame_done), 1);
            checkOutput("zero_busy", 32'(bus.busy), 0);
            tick();
            checkOutput("zero_frame_done_clear", 32'(bus.frame_done), 0);
            checkOutput("zero_busy_after", 32'(bus.busy), 0);
        end else begin
            checkOutput("start_loads_left", 32'(bus.mcus_left), 32'(n));
            checkOutput("start_busy", 32'(bus.busy), 1);
        end
    endtask

    task automatic feedWrites(input int count, input int maxGap, input int errPct);
        logic [1:0] wrong;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, maxGap)) tick();
            if (errPct > 0 && $urandom_range(0, 99) < errPct) begin
                wrong = expChan() + 2'($urandom_range(1, 3));
                applyStimulus(wrong);
            end
            applyStimulus(expChan());
        end
    endtask

    task automatic finishFrame();
        int budget;
        budget = 0;
        while (!bus.frame_done && budget < 20) begin
            tick();
            budget++;
        end
        checkOutput("frame_done_seen", 32'(bus.frame_done), 1);
        tick();
        checkOutput("mcus_left_end", 32'(bus.mcus_left), 0);
        checkOutput("seq_err_end", 32'(bus.seq_err), 32'(modelErr));
        checkOutput("busy_end", 32'(bus.busy), 0);
    endtask

    task automatic runFrame(input int n, input int maxGap, input int errPct);
        startFrame(MCU_W'(n));
        feedWrites(6 * n, maxGap, errPct);
        finishFrame();
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({bus.in_ready, bus.buf_wr_en, bus.buf_ch, bus.drain_active, bus.mcu_done,
                    bus.frame_done, bus.busy, bus.seq_err, bus.mcus_left});
    endfunction

    always @(negedge clk) begin : monitor
        event_t ev;
        int     actKind;
        if (rst_n) begin
            if (prevFrameDone) checkOutput("busy_after_frame_done", 32'(bus.busy), 0);
            prevFrameDone = bus.frame_done;
            if (bus.drain_active) begin
                drainRun++;
                checkOutput("in_ready_during_drain", 32'(bus.in_ready), 0);
            end
            if (bus.buf_wr_en || bus.mcu_done || bus.frame_done) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_event: wr=%0b mcu=%0b fd=%0b, expected none",
                             bus.buf_wr_en, bus.mcu_done, bus.frame_done);
                end else begin
                    ev      = expQ.pop_front();
                    actKind = bus.buf_wr_en ? K_WRITE : (bus.mcu_done ? K_MCU : K_ZERO);
                    checkOutput("event_kind", 32'(actKind), 32'(ev.kind));
                    if (ev.kind == K_WRITE && bus.buf_wr_en)
                        checkOutput("buf_ch", 32'(bus.buf_ch), 32'(ev.ch));
                    if (ev.kind == K_MCU && bus.mcu_done) begin
                        checkOutput("mcus_left_at_mcu_done", 32'(bus.mcus_left), 32'(ev.left));
                        checkOutput("frame_done_at_mcu_done", 32'(bus.frame_done), 32'(ev.fd));
                        checkOutput("drain_length", 32'(drainRun), 4);
                    end
                end
            end
            if (bus.mcu_done) drainRun = 0;
        end else begin
            drainRun      = 0;
            prevFrameDone = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start    = 1'b0;
        bus.num_mcus = '0;
        bus.in_valid = 1'b0;
        bus.in_ch    = 2'd0;
        #3;
        checkOutput("reset_outputs", allOutputs(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", allOutputs(), 0);

        // Single MCU, back-to-back writes.
        runFrame(1, 0, 0);

        // Three MCUs with random gaps.
        runFrame(3, 3, 0);

        // Wrong tag after two Y writes: consumed, flagged, Y count kept.
        startFrame(1);
        applyStimulus(2'd0);
        applyStimulus(2'd0);
        applyStimulus(2'd1);
        checkOutput("seq_err_set", 32'(bus.seq_err), 1);
        feedWrites(4, 1, 0);
        finishFrame();

        // Zero-MCU frame.
        startFrame('0);

        // Start while busy is ignored.
        startFrame(3);
        feedWrites(1, 0, 0);
        bus.start    = 1'b1;
        bus.num_mcus = MCU_W'(7);
        tick();
        bus.start = 1'b0;
        checkOutput("busy_start_ignored", 32'(bus.mcus_left), 3);
        feedWrites(17, 2, 0);
        finishFrame();

        // Reset during the second drain cycle.
        startFrame(1);
        feedWrites(6, 0, 0);
        @(posedge clk);
        #2;
        checkOutput("drain_before_reset", 32'(bus.drain_active), 1);
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("reset_mid_drain", allOutputs(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        runFrame(1, 2, 0);

        // Randomized frames with occasional out-of-order tags.
        for (int f = 0; f < 4; f++) begin
            runFrame($urandom_range(1, 4), 3, 15);
        end

        repeat (3) tick();
        checkOutput("queue_empty", 32'(expQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
